ahb3lite_mem_ws: RTL and testbench
==================================

Name: ahb3lite_mem_ws

Overview:
Parametrised AHB3-Lite memory slave and the successor of the current fixed-width memory slave. Adds a configurable data width, depth, base address and fixed wait-state insertion, plus byte, halfword and word sub-word access through HSIZE. An optional two-cycle ERROR response covers illegal accesses. It sits behind the interconnect decoder as a single slave, and its HREADYOUT is fed back as HREADY in standalone benches.

Parameters:
HADDR_SIZE, 32, address bus width
HDATA_SIZE, 32, data bus width; legal values 32 or 64
MEM_DEPTH, 256, number of HDATA_SIZE-wide words
WAIT_STATES, 0, wait cycles inserted in every OKAY data phase; legal range 0..15
BASE_ADDR, 0, byte address of word 0

Ports:
HCLK  in  1  bus clock; all logic on the rising edge
HRESET  in  1  synchronous reset, active-high
HSEL  in  1  slave select
HADDR  in  HADDR_SIZE  byte address
HWDATA  in  HDATA_SIZE  write data, valid in the data phase
HRDATA  out  HDATA_SIZE  read data
HWRITE  in  1  1 = write, 0 = read
HSIZE  in  3  transfer size: 0 = byte, 1 = half, 2 = word, 3 = dword
HBURST  in  3  burst type; accepted, not decoded (each beat carries its own address)
HPROT  in  4  ignored
HTRANS  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ
HREADY  in  1  bus ready; a transfer is accepted only when HREADY is 1
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset (HRESET=1 on a clock edge): HREADYOUT=1, HRESP=0, HRDATA=0, FSM goes to IDLE, wait counter = 0. Memory contents are not reset.
- Address-phase accept condition: HSEL & HREADY & HTRANS[1].
  - On accept, register HADDR, HSIZE and HWRITE, and compute the legality check.
  - IDLE or BUSY with HSEL=1: zero-wait OKAY, no memory access.
- Word index = (HADDR - BASE_ADDR) >> log2(HDATA_SIZE/8).
  - Byte-lane mask comes from HSIZE and the low address bits, little-endian.
- FSM states: IDLE, DATA, ERR1, ERR2.
  - IDLE -> DATA on a legal accept; wait counter loads WAIT_STATES.
  - DATA, counter > 0: HREADYOUT=0, decrement the counter.
  - DATA, counter = 0: HREADYOUT=1, HRESP=0.
    - Write: commit the masked HWDATA lanes at this edge.
    - Read: HRDATA = full stored word, combinationally from the registered index; all lanes are driven.
  - When DATA completes: go to DATA again if a new legal accept occurs in the same cycle (pipelined back-to-back), to ERR1 if the accept is illegal, else to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. No memory access, wait states not applied.
  - ERR1 -> ERR2: HREADYOUT=1, HRESP=1.
  - ERR2 -> IDLE, or DATA/ERR1 if a transfer is accepted in that cycle.
- HRDATA = 0 whenever not in a completing read data phase.
- Read-after-write to the same word, back-to-back: the write commits at the end of its data phase, so the following read returns the new data. No forwarding is needed.
- Reset asserted mid data phase or during a wait state aborts the transfer. A pending write is not committed.
- BUSY inside a burst while in IDLE: OKAY, zero wait, counter untouched.

Optional Feature:
AHB_MEM_ERR_EN.
- Defined: an accept is illegal, and takes ERR1/ERR2, when any of these holds:
  - the address is outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH*HDATA_SIZE/8);
  - the address is misaligned for HSIZE;
  - HSIZE > log2(HDATA_SIZE/8).
  An illegal write never modifies memory.
- Not defined: every accept is legal. The word index wraps modulo MEM_DEPTH, address bits below the HSIZE alignment are forced to 0, an oversize HSIZE is treated as a full-width access, and HRESP is tied to 0.

Test Plan:
- Reset, then a NONSEQ word write of 0xDEADBEEF to 0x10 followed by a read of 0x10, with WAIT_STATES=0 -> read data phase returns 0xDEADBEEF, HREADYOUT=1 throughout, HRESP=0.
- WAIT_STATES=3, word write then read of 0x20 -> HREADYOUT low for exactly 3 cycles in each data phase; read returns the written value.
- Write 0x11223344 to 0x0, then byte write 0xAA to 0x1 and halfword write 0xBBCC to 0x2, then word read of 0x0 -> 0xBBCCAA44.
- 4-beat INCR word burst (NONSEQ then 3×SEQ, with one BUSY inserted) writing 1, 2, 3, 4 at 0x40, then read back -> data 1, 2, 3, 4; the BUSY beat gets OKAY with zero wait.
- With AHB_MEM_ERR_EN, WAIT_STATES=2:
  - word write to 0x402 (misaligned) -> HRESP=1 with HREADYOUT=0, then HRESP=1 with HREADYOUT=1; memory unchanged.
  - access to address 0x400 with MEM_DEPTH=256, 32-bit -> same two-cycle ERROR.
  - without the macro, a write to 0x400 aliases word 0.
- Assert HRESET during the 2nd wait cycle of a write of 0x55 to 0x8 -> outputs reach reset values on the next edge; a later read of 0x8 returns the old value.

Source files
------------

// File: rtl/ahb3lite_mem_ws.sv
// rtl/ahb3lite_mem_ws.sv - parametrised AHB3-Lite memory slave with fixed wait states and sub-word access
// Optional AHB_MEM_ERR_EN: out-of-range, misaligned or oversize accepts get a two-cycle ERROR response.
module ahb3lite_mem_ws #(
    parameter int                    HADDR_SIZE  = 32,
    parameter int                    HDATA_SIZE  = 32,
    parameter int                    MEM_DEPTH   = 256,
    parameter int                    WAIT_STATES = 0,
    parameter logic [HADDR_SIZE-1:0] BASE_ADDR   = '0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int BYTES = HDATA_SIZE / 8;
    localparam int ALSB  = $clog2(BYTES);
    localparam int IDXW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [HADDR_SIZE-1:0] SPAN = HADDR_SIZE'(MEM_DEPTH * BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                  state, state_nxt;
    logic [3:0]              cnt;
    logic [IDXW-1:0]         idx_q;
    logic [BYTES-1:0]        mask_q;
    logic                    write_q;
    logic [HDATA_SIZE-1:0]   mem [MEM_DEPTH];

    logic                    accept, legal, phase_done, take, commit;
    logic [HADDR_SIZE-1:0]   offset, word_off;
    logic [IDXW-1:0]         idx_d;
    logic [BYTES-1:0]        mask_d;
    logic [2:0]              eff_size;
    logic [ALSB-1:0]         lo;
    logic                    unused_ok;

    assign unused_ok = ^{HBURST, HPROT};

    assign accept   = HSEL & HREADY & HTRANS[1];
    assign offset   = HADDR - BASE_ADDR;
    assign word_off = offset >> ALSB;
    assign idx_d    = IDXW'(word_off % HADDR_SIZE'(MEM_DEPTH));
    assign lo       = HADDR[ALSB-1:0];
    assign eff_size = (HSIZE > 3'(ALSB)) ? 3'(ALSB) : HSIZE;

    // A lane is enabled when it falls in the same size-aligned chunk as the address,
    // which also drops address bits below the transfer alignment.
    always_comb begin
        mask_d = '0;
        for (int b = 0; b < BYTES; b++) begin
            mask_d[b] = ((b >> eff_size) == (int'(lo) >> eff_size));
        end
    end

`ifdef AHB_MEM_ERR_EN
    logic misalign;

    always_comb begin
        misalign = 1'b0;
        for (int i = 0; i < ALSB; i++) begin
            if (i < int'(HSIZE) && lo[i]) misalign = 1'b1;
        end
    end

    assign legal = (HADDR >= BASE_ADDR) && (offset < SPAN) && !misalign && (int'(HSIZE) <= ALSB);
`else
    assign legal = 1'b1;
`endif

    assign phase_done = (state == S_IDLE) || (state == S_ERR2) || ((state == S_DATA) && (cnt == 4'd0));
    assign take       = accept && phase_done;

    always_comb begin
        state_nxt = state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            S_DATA: begin
                if (cnt != 4'd0) HREADYOUT = 1'b0;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
`ifdef AHB_MEM_ERR_EN
                HRESP     = 1'b1;
`endif
            end
            S_ERR2: begin
`ifdef AHB_MEM_ERR_EN
                HRESP     = 1'b1;
`endif
            end
            default: ;
        endcase
        if (state == S_ERR1) begin
            state_nxt = S_ERR2;
        end else if (phase_done) begin
            state_nxt = take ? (legal ? S_DATA : S_ERR1) : S_IDLE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            mask_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                idx_q   <= idx_d;
                mask_q  <= mask_d;
                write_q <= HWRITE;
                if (legal) cnt <= 4'(WAIT_STATES);
            end else if ((state == S_DATA) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign commit = (state == S_DATA) && (cnt == 4'd0) && write_q;

    // Contents survive reset; a reset edge only suppresses a pending commit.
    always_ff @(posedge HCLK) begin
        if (!HRESET && commit) begin
            for (int b = 0; b < BYTES; b++) begin
                if (mask_q[b]) mem[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
            end
        end
    end

    assign HRDATA = ((state == S_DATA) && (cnt == 4'd0) && !write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb3lite_mem_ws.sv
// tb/tb_ahb3lite_mem_ws.sv - self-checking bench for ahb3lite_mem_ws against a byte-array reference model
module tb_ahb3lite_mem_ws;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int WS    = 2;
    localparam int BYTES = DW / 8;
`ifdef AHB_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [AW-1:0] HADDR;
    logic [DW-1:0] HWDATA, HRDATA;
    logic [2:0]    HSIZE, HBURST;
    logic [3:0]    HPROT;
    logic [1:0]    HTRANS;

    ahb3lite_mem_ws #(
        .HADDR_SIZE (AW),
        .HDATA_SIZE (DW),
        .MEM_DEPTH  (DEPTH),
        .WAIT_STATES(WS),
        .BASE_ADDR  (32'h0)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HWDATA   (HWDATA),
        .HRDATA   (HRDATA),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HBURST   (HBURST),
        .HPROT    (HPROT),
        .HTRANS   (HTRANS),
        .HREADY   (HREADY),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP)
    );

    assign HREADY = HREADYOUT;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } beat_t;

    beat_t       beats[$];
    logic [7:0]  model[DEPTH*BYTES];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t idle_b();
        beat_t b;
        b.trans = 2'd0; b.write = 1'b0; b.addr = 32'h0; b.size = 3'd2; b.data = 32'h0;
        return b;
    endfunction

    task automatic push(input logic [1:0] t, input logic w, input logic [31:0] a,
                        input logic [2:0] s, input logic [31:0] d);
        beat_t b;
        b.trans = t; b.write = w; b.addr = a; b.size = s; b.data = d;
        beats.push_back(b);
    endtask

    function automatic bit is_legal(input logic [31:0] a, input logic [2:0] sz);
        bit ok;
        ok = (a < DEPTH * BYTES) && ((a % (32'd1 << sz)) == 0) && (sz <= 3'd2);
        return ok || !ERR_EN;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int w;
        w = int'((a / BYTES) % DEPTH);
        return {model[w*4+3], model[w*4+2], model[w*4+1], model[w*4]};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        int es, nb, lane0, w;
        es    = (sz > 3'd2) ? 2 : int'(sz);
        nb    = 1 << es;
        lane0 = (int'(a % BYTES) / nb) * nb;
        w     = int'((a / BYTES) % DEPTH);
        for (int i = 0; i < nb; i++) model[w*BYTES + lane0 + i] = d[(lane0+i)*8 +: 8];
    endtask

    task automatic drive(input beat_t a, input logic [31:0] wd);
        HSEL   = 1'b1;
        HTRANS = a.trans;
        HADDR  = a.addr;
        HWRITE = a.write;
        HSIZE  = a.size;
        HBURST = (a.trans != 2'd0) ? 3'b001 : 3'b000;
        HWDATA = wd;
    endtask

    // Pipelined master: each beat's data phase lasts until HREADYOUT is seen high.
    task automatic run_q();
        beat_t       a, d;
        int          k;
        bit          xfer, lg, er, ep;
        logic [31:0] ed;
        d = idle_b();
        k = 0;
        a = (beats.size() > 0) ? beats.pop_front() : idle_b();
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (!d.trans[1] && !a.trans[1] && beats.size() == 0) break;
            drive(a, d.data);
            xfer = d.trans[1];
            lg   = xfer && is_legal(d.addr, d.size);
            if (!xfer)   begin er = 1'b1;       ep = 1'b0; end
            else if (lg) begin er = (k == WS);  ep = 1'b0; end
            else         begin er = (k == 1);   ep = 1'b1; end
            ed = (lg && !d.write && k == WS) ? model_word(d.addr) : 32'h0;
            chk("hreadyout", HREADYOUT, er);
            chk("hresp", HRESP, ep);
            chk("hrdata", HRDATA, ed);
            if (HREADYOUT) begin
                if (lg && !d.write) last_rdata = HRDATA;
                if (lg && d.write) model_write(d.addr, d.size, d.data);
                d = a;
                k = 0;
                a = (beats.size() > 0) ? beats.pop_front() : idle_b();
            end else begin
                k++;
                if (k > WS + 4) begin
                    chk("timeout", 1, 0);
                    beats.delete();
                    drive(idle_b(), 32'h0);
                    return;
                end
            end
            @(posedge HCLK); #1;
        end
        drive(idle_b(), 32'h0);
    endtask

    initial begin
        logic [31:0] old8, a;
        logic [2:0]  sz;
        int          r;

        HRESET = 1'b1;
        HPROT  = 4'b0011;
        drive(idle_b(), 32'h0);
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_hreadyout", HREADYOUT, 1);
        chk("rst_hresp", HRESP, 0);
        chk("rst_hrdata", HRDATA, 0);
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        for (int w = 0; w < DEPTH; w++) push(2'd2, 1'b1, 32'(w * 4), 3'd2, $urandom);
        run_q();

        push(2'd2, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        push(2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
        run_q();
        chk("raw_0x10", last_rdata, 32'hDEADBEEF);

        push(2'd2, 1'b1, 32'h20, 3'd2, 32'h0BADF00D);
        run_q();
        push(2'd2, 1'b0, 32'h20, 3'd2, 32'h0);
        run_q();
        chk("ws_0x20", last_rdata, 32'h0BADF00D);

        push(2'd2, 1'b1, 32'h0, 3'd2, 32'h11223344);
        push(2'd2, 1'b1, 32'h1, 3'd0, 32'h0000AA00);
        push(2'd2, 1'b1, 32'h2, 3'd1, 32'hBBCC0000);
        push(2'd2, 1'b0, 32'h0, 3'd2, 32'h0);
        run_q();
        chk("subword", last_rdata, 32'hBBCCAA44);

        push(2'd2, 1'b1, 32'h40, 3'd2, 32'd1);
        push(2'd3, 1'b1, 32'h44, 3'd2, 32'd2);
        push(2'd1, 1'b1, 32'h48, 3'd2, 32'd0);
        push(2'd3, 1'b1, 32'h48, 3'd2, 32'd3);
        push(2'd3, 1'b1, 32'h4C, 3'd2, 32'd4);
        for (int i = 0; i < 4; i++) push((i == 0) ? 2'd2 : 2'd3, 1'b0, 32'(32'h40 + i * 4), 3'd2, 32'h0);
        run_q();
        chk("burst_last", last_rdata, 32'd4);

        if (ERR_EN) begin
            push(2'd2, 1'b1, 32'h12, 3'd2, 32'h99999999);
            push(2'd2, 1'b1, 32'h402, 3'd2, 32'h77777777);
            push(2'd2, 1'b1, 32'h400, 3'd2, 32'h66666666);
            push(2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
            push(2'd2, 1'b0, 32'h0, 3'd2, 32'h0);
            run_q();
            chk("err_mem_unchanged", last_rdata, 32'hBBCCAA44);
        end else begin
            push(2'd2, 1'b1, 32'h400, 3'd2, 32'hCAFEF00D);
            push(2'd2, 1'b0, 32'h0, 3'd2, 32'h0);
            run_q();
            chk("alias_word0", last_rdata, 32'hCAFEF00D);
        end

        old8 = model_word(32'h8);
        drive(beat_t'{2'd2, 1'b1, 32'h8, 3'd2, 32'h55}, 32'h0);
        @(posedge HCLK); #1;
        drive(idle_b(), 32'h55);
        chk("rst_ws1_ready", HREADYOUT, 0);
        @(posedge HCLK); #1;
        chk("rst_ws2_ready", HREADYOUT, 0);
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        chk("midrst_hreadyout", HREADYOUT, 1);
        chk("midrst_hresp", HRESP, 0);
        chk("midrst_hrdata", HRDATA, 0);
        HRESET = 1'b0;
        push(2'd2, 1'b0, 32'h8, 3'd2, 32'h0);
        run_q();
        chk("midrst_old_value", last_rdata, old8);

        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 9);
            sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 2047));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            push((r == 0) ? 2'd0 : (r == 1) ? 2'd1 : 2'd2, 1'($urandom_range(0, 1)), a, sz, $urandom);
        end
        run_q();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
